// File: rtl/br_fifo_shared_pstatic_credit_sender.sv
`default_nettype none
// ============================================================================
// Module   : br_fifo_shared_pstatic_credit_sender
// Purpose  : Credit-based sender for a shared pseudo-static multi-FIFO.
//            Keeps one credit counter per logical FIFO, round-robin
//            arbitrates among credited sources and emits a single push
//            stream tagged with the target FIFO id.
// Revision : 1.0 - initial release
// ============================================================================
module br_fifo_shared_pstatic_credit_sender #(
    parameter int NumFifos            = 2,
    parameter int Width               = 1,
    parameter int MaxCredit           = 3,
    parameter int RegisterPushOutputs = 1,
    localparam int FifoIdWidth        = (NumFifos > 1) ? $clog2(NumFifos) : 1,
    localparam int CountWidth         = $clog2(MaxCredit + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NumFifos-1:0]                   src_valid,
    output logic [NumFifos-1:0]                   src_ready,
    input  logic [NumFifos-1:0][Width-1:0]        src_data,
    output logic                                  push_sender_in_reset,
    input  logic                                  push_receiver_in_reset,
    input  logic [NumFifos-1:0]                   credit_stall,
    output logic [NumFifos-1:0]                   push_credit_stall,
    input  logic [NumFifos-1:0]                   push_credit,
    output logic                                  push_valid,
    output logic [Width-1:0]                      push_data,
    output logic [FifoIdWidth-1:0]                push_fifo_id,
    input  logic [NumFifos-1:0][CountWidth-1:0]   credit_initial,
    input  logic [NumFifos-1:0][CountWidth-1:0]   credit_withhold,
    output logic [NumFifos-1:0][CountWidth-1:0]   credit_count,
    output logic [NumFifos-1:0][CountWidth-1:0]   credit_available
);

    localparam logic [FifoIdWidth-1:0] c_last_id  = FifoIdWidth'(NumFifos - 1);
    localparam logic [CountWidth-1:0]  c_max_cred = CountWidth'(MaxCredit);

    logic                                r_sender_in_reset;
    logic                                w_in_reset;
    logic [NumFifos-1:0][CountWidth-1:0] r_count;
    logic [NumFifos-1:0][CountWidth-1:0] w_available;
    logic [NumFifos-1:0]                 w_eligible;
    logic [NumFifos-1:0]                 w_grant;
    logic                                w_any_grant;
    logic [FifoIdWidth-1:0]              w_grant_idx;
    logic [FifoIdWidth-1:0]              r_ptr;
    logic [Width-1:0]                    w_grant_data;

    assign push_sender_in_reset = r_sender_in_reset;
    assign w_in_reset           = r_sender_in_reset || push_receiver_in_reset;
    assign push_credit_stall    = credit_stall;
    assign credit_count         = r_count;
    assign credit_available     = w_available;
    assign src_ready            = w_grant;
    assign w_grant_data         = src_data[w_grant_idx];

    // Sender-in-reset flag: set by reset, cleared on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sender_in_reset <= 1'b1;
        end else begin
            r_sender_in_reset <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NumFifos; gi++) begin : g_fifo
            // Withheld credits are not usable; floor the difference at zero.
            assign w_available[gi] = (r_count[gi] > credit_withhold[gi])
                                   ? (r_count[gi] - credit_withhold[gi])
                                   : '0;
            assign w_eligible[gi]  = src_valid[gi] && (w_available[gi] != '0) && !w_in_reset;

            // Credit counter: reload while in reset, else add returns and subtract grants.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count[gi] <= '0;
                end else if (w_in_reset) begin
                    r_count[gi] <= credit_initial[gi];
                end else if (push_credit[gi] && !w_grant[gi]) begin
                    r_count[gi] <= r_count[gi] + 1'b1;
                end else if (!push_credit[gi] && w_grant[gi]) begin
                    r_count[gi] <= r_count[gi] - 1'b1;
                end
            end

`ifndef SYNTHESIS
            a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                !(!w_in_reset && push_credit[gi] && !w_grant[gi] && (r_count[gi] == c_max_cred)));
            a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
                (r_count[gi] <= c_max_cred));
`ifdef BR_INTEGRATION_CHECKS
            a_src_stable  : assert property (@(posedge clk) disable iff (!rst_n || w_in_reset)
                (src_valid[gi] && !src_ready[gi]) |=> src_valid[gi]);
`endif
`endif
        end
    endgenerate

    // Round-robin pick: first eligible FIFO at or after the priority pointer.
    always_comb begin
        int idx;
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_grant_idx = '0;
        idx         = 0;
        for (int off = 0; off < NumFifos; off++) begin
            idx = int'(r_ptr) + off;
            if (idx >= NumFifos) begin
                idx = idx - NumFifos;
            end
            if (!w_any_grant && w_eligible[idx]) begin
                w_any_grant  = 1'b1;
                w_grant[idx] = 1'b1;
                w_grant_idx  = FifoIdWidth'(idx);
            end
        end
    end

    // Priority pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any_grant) begin
            r_ptr <= (w_grant_idx == c_last_id) ? '0 : (w_grant_idx + 1'b1);
        end
    end

    generate
        if (RegisterPushOutputs != 0) begin : g_reg_out
            logic                   r_push_valid;
            logic [Width-1:0]       r_push_data;
            logic [FifoIdWidth-1:0] r_push_fifo_id;

            // Output flop stage; data/id hold between grants, valid cleared in reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_push_valid   <= 1'b0;
                    r_push_data    <= '0;
                    r_push_fifo_id <= '0;
                end else if (w_in_reset) begin
                    r_push_valid   <= 1'b0;
                end else begin
                    r_push_valid <= w_any_grant;
                    if (w_any_grant) begin
                        r_push_data    <= w_grant_data;
                        r_push_fifo_id <= w_grant_idx;
                    end
                end
            end

            // A push already in the flop is dropped once the receiver enters reset.
            assign push_valid   = r_push_valid && !push_receiver_in_reset;
            assign push_data    = r_push_data;
            assign push_fifo_id = r_push_fifo_id;
        end else begin : g_comb_out
            assign push_valid   = w_any_grant;
            assign push_data    = w_any_grant ? w_grant_data : '0;
            assign push_fifo_id = w_grant_idx;
        end
    endgenerate

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(src_ready));
    a_no_push_in_rx_reset : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_valid && push_receiver_in_reset));
`endif

endmodule
`default_nettype wire
